// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle control sequencer
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALUB_RD2  = 2'b00;
  localparam logic [1:0] ALUB_IMM  = 2'b01;
  localparam logic [1:0] ALUB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

endpackage

// File: rtl/ctrl_out_dec.sv
// rtl/ctrl_out_dec.sv - combinational state to datapath-control decoder
module ctrl_out_dec
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic       ready_i,
  output logic       mem_req_o,
  output logic       adr_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       alu_op_o,
  output logic [1:0] result_src_o,
  output logic       ir_write_o,
  output logic       next_pc_o,
  output logic       reg_w_o,
  output logic       mem_w_o,
  output logic       branch_o
);

  always_comb begin
    mem_req_o    = 1'b0;
    adr_src_o    = ADR_PC;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = ALUB_RD2;
    alu_op_o     = 1'b0;
    result_src_o = RES_ALUOUT;
    ir_write_o   = 1'b0;
    next_pc_o    = 1'b0;
    reg_w_o      = 1'b0;
    mem_w_o      = 1'b0;
    branch_o     = 1'b0;
    unique case (state_i)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = ALUB_FOUR;
        result_src_o = RES_ALURES;
        ir_write_o   = ready_i;
        next_pc_o    = ready_i;
      end
      S_DECODE: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = ALUB_FOUR;
        result_src_o = RES_ALURES;
      end
      S_MEMADR: alu_src_b_o = ALUB_IMM;
      S_MEMRD: begin
        mem_req_o = 1'b1;
        adr_src_o = ADR_ALUOUT;
      end
      S_MEMWB: begin
        result_src_o = RES_DATA;
        reg_w_o      = 1'b1;
      end
      S_MEMWR: begin
        mem_req_o = 1'b1;
        adr_src_o = ADR_ALUOUT;
        mem_w_o   = 1'b1;
      end
      S_EXECUTER: alu_op_o = 1'b1;
      S_EXECUTEI: begin
        alu_src_b_o = ALUB_IMM;
        alu_op_o    = 1'b1;
      end
      S_ALUWB: reg_w_o = 1'b1;
      S_BRANCH: begin
        alu_src_b_o  = ALUB_IMM;
        result_src_o = RES_ALURES;
        branch_o     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - fetch/decode/execute/memory/writeback sequencer
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               adr_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               alu_op,
  output logic [1:0]         result_src,
  output logic               ir_write,
  output logic               next_pc,
  output logic               reg_w,
  output logic               mem_w,
  output logic               branch,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_e state_q, state_d, dec_state;
  logic   ready;
  logic   d_mem_req, d_ir_write, d_next_pc, d_reg_w, d_mem_w, d_branch;
  logic   unused_funct;

  assign ready        = USE_MEM_READY ? mem_ready : 1'b1;
  assign unused_funct = ^funct[4:1];

  always_comb begin
    state_d = S_FETCH;
    if (!reset) begin
      unique case (state_q)
        S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          unique case (op)
            OP_MEM:  state_d = S_MEMADR;
            OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
            OP_BR:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
        S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:    state_d = ready ? S_MEMWB : S_MEMRD;
        S_MEMWR:    state_d = ready ? S_FETCH : S_MEMWR;
        S_EXECUTER: state_d = S_ALUWB;
        S_EXECUTEI: state_d = S_ALUWB;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // During reset the mux selects show FETCH values; every enable is forced low.
  assign dec_state = reset ? S_FETCH : state_q;

  ctrl_out_dec u_out_dec (
    .state_i      (dec_state),
    .ready_i      (ready),
    .mem_req_o    (d_mem_req),
    .adr_src_o    (adr_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .result_src_o (result_src),
    .ir_write_o   (d_ir_write),
    .next_pc_o    (d_next_pc),
    .reg_w_o      (d_reg_w),
    .mem_w_o      (d_mem_w),
    .branch_o     (d_branch)
  );

  assign mem_req    = d_mem_req  & ~reset;
  assign ir_write   = d_ir_write & ~reset;
  assign next_pc    = d_next_pc  & ~reset;
  assign reg_w      = d_reg_w    & ~reset;
  assign mem_w      = d_mem_w    & ~reset;
  assign branch     = d_branch   & ~reset;
  assign illegal_op = ~reset & (state_q == S_DECODE) & (op == 2'b11);
  assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized model-checked bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_req, adr_src, alu_src_a, alu_op, ir_write, next_pc, reg_w, mem_w, branch, illegal_op;
  logic [1:0] alu_src_b, result_src;
  logic [3:0] state_dbg;

  logic       reset2;
  logic [1:0] op2;
  logic [5:0] funct2;
  logic       mem_req2, adr_src2, alu_src_a2, alu_op2, ir_write2, next_pc2, reg_w2, mem_w2, branch2, illegal_op2;
  logic [1:0] alu_src_b2, result_src2;
  logic [3:0] state_dbg2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.USE_MEM_READY(1'b1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .ir_write(ir_write), .next_pc(next_pc),
    .reg_w(reg_w), .mem_w(mem_w), .branch(branch), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  multicycle_ctrl_fsm #(.USE_MEM_READY(1'b0), .STATE_W(4)) dut_nr (
    .clk(clk), .reset(reset2), .op(op2), .funct(funct2), .mem_ready(1'b0),
    .mem_req(mem_req2), .adr_src(adr_src2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
    .alu_op(alu_op2), .result_src(result_src2), .ir_write(ir_write2), .next_pc(next_pc2),
    .reg_w(reg_w2), .mem_w(mem_w2), .branch(branch2), .illegal_op(illegal_op2), .state_dbg(state_dbg2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int enc(bit mr, bit adr, bit a, int b, bit aop, int res,
                             bit ir, bit npc, bit rw, bit mw, bit br, bit ill);
    return (int'(mr) << 13) | (int'(adr) << 12) | (int'(a) << 11) | (b << 9) |
           (int'(aop) << 8) | (res << 6) | (int'(ir) << 5) | (int'(npc) << 4) |
           (int'(rw) << 3) | (int'(mw) << 2) | (int'(br) << 1) | int'(ill);
  endfunction

  // Expected control word per state, straight from the per-state output table.
  function automatic int model_outs(int st, bit rdy, logic [1:0] opv, bit rst);
    if (rst) return enc(0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0, 0);
    case (st)
      0:       return enc(1, 0, 1, 2, 0, 2, rdy, rdy, 0, 0, 0, 0);
      1:       return enc(0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0, opv == 2'b11);
      2:       return enc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      3:       return enc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      4:       return enc(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      5:       return enc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      6:       return enc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      7:       return enc(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      8:       return enc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      9:       return enc(0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1, 0);
      default: return -1;
    endcase
  endfunction

  function automatic int dut_outs();
    return enc(mem_req, adr_src, alu_src_a, int'(alu_src_b), alu_op, int'(result_src),
               ir_write, next_pc, reg_w, mem_w, branch, illegal_op);
  endfunction

  function automatic int dut2_outs();
    return enc(mem_req2, adr_src2, alu_src_a2, int'(alu_src_b2), alu_op2, int'(result_src2),
               ir_write2, next_pc2, reg_w2, mem_w2, branch2, illegal_op2);
  endfunction

  int  exp_st[$];
  bit  exp_rdy[$];

  task automatic push(input int st, input bit rdy);
    exp_st.push_back(st);
    exp_rdy.push_back(rdy);
  endtask

  // One clock: drive ready, compare at the falling edge, return just after the next rising edge.
  task automatic cycle(input int st, input bit rdy);
    mem_ready = rdy;
    @(negedge clk);
    check("state", int'(state_dbg), st);
    check($sformatf("outs st%0d", st), dut_outs(), model_outs(st, rdy, op, 1'b0));
    @(posedge clk);
    #1;
  endtask

  // Instruction is described by its class path plus fetch and memory wait counts.
  task automatic run_instr(input logic [1:0] opv, input logic [5:0] fv, input int wf, input int wm);
    exp_st.delete();
    exp_rdy.delete();
    op    = opv;
    funct = fv;
    repeat (wf) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'($urandom));
    case (opv)
      2'b00: begin
        push(fv[5] ? 7 : 6, 1'($urandom));
        push(8, 1'($urandom));
      end
      2'b01: begin
        push(2, 1'($urandom));
        if (fv[0]) begin
          repeat (wm) push(3, 1'b0);
          push(3, 1'b1);
          push(4, 1'($urandom));
        end else begin
          repeat (wm) push(5, 1'b0);
          push(5, 1'b1);
        end
      end
      2'b10: push(9, 1'($urandom));
      default: ;
    endcase
    foreach (exp_st[i]) cycle(exp_st[i], exp_rdy[i]);
  endtask

  int nr_seq[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 2'b00; funct = 6'd0;
    reset2 = 1'b1; op2 = 2'b01; funct2 = 6'b011001;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset state", int'(state_dbg), 0);
    check("reset outs", dut_outs(), model_outs(0, 1'b1, op, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(2'b00, 6'b001000, 0, 0);
    run_instr(2'b01, 6'b011001, 0, 2);
    run_instr(2'b01, 6'b011000, 1, 1);
    run_instr(2'b10, 6'b000000, 0, 0);
    run_instr(2'b11, 6'b101011, 0, 0);

    // Reset in a stalled store abandons it and suppresses mem_w that cycle.
    op = 2'b01; funct = 6'b000000;
    cycle(0, 1'b1);
    cycle(1, 1'b1);
    cycle(2, 1'b1);
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst memwr state", int'(state_dbg), 5);
    check("rst memwr mem_w", int'(mem_w), 0);
    check("rst memwr outs", dut_outs(), model_outs(5, 1'b0, op, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(2'b00, 6'b100100, 0, 0);

    for (int n = 0; n < 60; n++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 3));
    end

    reset2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("nr state", int'(state_dbg2), nr_seq[k]);
      check("nr outs", dut2_outs(), model_outs(nr_seq[k], 1'b1, op2, 1'b0));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main sequencer of the multicycle ARM-like core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the select lines of the datapath's 2:1/3:1 operand and result muxes and the register, PC and memory write enables. It supports memory wait states through a ready handshake.

Parameters:
USE_MEM_READY, 1, when 0 mem_ready is ignored and treated as constant 1 (zero-wait memory)
STATE_W, 4, width of the state register and the state_dbg port

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal
funct  input  6  instr[25:20]; funct[5]=I (immediate), funct[0]=L (load)
mem_ready  input  1  memory has completed the current access this cycle
mem_req  output  1  memory access active (FETCH, MEMRD, MEMWR)
adr_src  output  1  address mux select: 0=PC, 1=ALUOut
alu_src_a  output  1  0=RD1 register, 1=PC
alu_src_b  output  2  00=RD2, 01=ExtImm, 10=constant 4
alu_op  output  1  1=ALU decoder uses funct (DP execute), 0=forced ADD
result_src  output  2  00=ALUOut, 01=Data, 10=ALUResult
ir_write  output  1  instruction register load enable
next_pc  output  1  PC update with PC+4
reg_w  output  1  register-file write enable (pre-condition-check)
mem_w  output  1  memory write enable (pre-condition-check)
branch  output  1  branch PC-load request (pre-condition-check)
illegal_op  output  1  one-cycle pulse: op=11 decoded
state_dbg  output  STATE_W  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Encodings 10-15 are unreachable and must go to FETCH on the next edge.
- Reset: while reset=1, the next-state is FETCH. ir_write, next_pc, reg_w, mem_w, branch, mem_req and illegal_op are forced 0 combinationally. Mux selects take their FETCH values. Reset mid-instruction abandons the instruction and does not complete it. The first cycle after reset is FETCH.
- Transitions:
  - FETCH→DECODE when mem_ready; otherwise stay in FETCH.
  - From DECODE: op=01→MEMADR; op=00 with funct[5]=0→EXECUTER; op=00 with funct[5]=1→EXECUTEI; op=10→BRANCH; op=11→FETCH with illegal_op=1 for that DECODE cycle.
  - MEMADR→MEMRD if funct[0]=1, else →MEMWR.
  - MEMRD→MEMWB on mem_ready, else stay.
  - MEMWR→FETCH on mem_ready, else stay.
  - MEMWB, ALUWB and BRANCH→FETCH.
  - EXECUTER and EXECUTEI→ALUWB.
- Outputs are Moore (functions of state) except the ready-qualified enables. Unlisted outputs are 0.
  - FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, alu_op=0, result_src=10, mem_req=1, ir_write=next_pc=mem_ready.
  - DECODE: alu_src_a=1, alu_src_b=10, result_src=10 (register read, PC+8).
  - MEMADR: alu_src_a=0, alu_src_b=01.
  - MEMRD: adr_src=1, mem_req=1, result_src=00.
  - MEMWB: result_src=01, reg_w=1.
  - MEMWR: adr_src=1, mem_req=1, mem_w=1. mem_w is held high for every wait cycle.
  - EXECUTER: alu_src_b=00, alu_op=1.
  - EXECUTEI: alu_src_b=01, alu_op=1.
  - ALUWB: result_src=00, reg_w=1.
  - BRANCH: alu_src_b=01, result_src=10, branch=1.
- Zero-wait latency in cycles: DP=4, LDR=5, STR=4, B=3.
- Each wait cycle with mem_ready=0 adds exactly one cycle. No output other than the ready-qualified enables changes during a wait.
- reg_w, mem_w and branch are pre-condition requests. Condition gating lives in the downstream cond logic and is not this block's concern.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding localparams;
  - op codes (OP_DP, OP_MEM, OP_BR);
  - mux-select constants (ALUB_RD2/IMM/FOUR, RES_ALUOUT/DATA/ALURES, ADR_PC/ALUOUT).
- One sub-module, ctrl_out_dec: a purely combinational state→output decoder. The top keeps the state register, next-state logic and reset gating.

Test Plan:
- DP register instr (op=00, funct=6'b001000), mem_ready=1 → states 0,1,6,8,0. reg_w=1 only in cycle 4, with result_src=00. ir_write and next_pc=1 only in cycle 1.
- LDR (op=01, funct=6'b011001), mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4. adr_src=1 and mem_req=1 throughout MEMRD. reg_w=1 with result_src=01 in state 4. Total 7 cycles.
- STR (op=01, funct[0]=0), FETCH stalled 1 cycle → FETCH held 2 cycles with ir_write=0 in the first and 1 in the second. mem_w=1 for the whole of MEMWR. reg_w never asserted.
- Branch (op=10) → states 0,1,9,0. branch=1, alu_src_b=01, result_src=10 in state 9.
- op=11 → illegal_op=1 for the DECODE cycle only, then FETCH. No reg_w, mem_w or branch asserted.
- reset asserted during MEMWR with mem_ready=0 → mem_w=0 in that same cycle. FETCH follows reset deassertion. USE_MEM_READY=0 with mem_ready tied 0 → LDR completes in 5 cycles.
